// File: rtl/dmem_lsu_if.sv
// Request/response and memory-port bundle for the load/store unit.
//
// Handshake: a request transfers on any posedge where req_valid && req_ready
// are both high; the request fields must be stable while req_valid is high.
// resp_valid is a one-cycle pulse with no backpressure, and resp_rdata and
// resp_err are meaningful only while it is high. mem_read/mem_write are
// single-cycle strobes, never high together; mem_rdata must be valid before
// the posedge that ends a mem_read cycle.
interface dmem_lsu_if #(
    parameter int WORD_ADDR_W = 8
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [1:0]             req_size;
    logic                   req_signed;
    logic [WORD_ADDR_W+1:0] req_addr;
    logic [31:0]            req_wdata;

    logic                   resp_valid;
    logic [31:0]            resp_rdata;
    logic                   resp_err;

    logic                   mem_read;
    logic                   mem_write;
    logic [WORD_ADDR_W-1:0] mem_addr;
    logic [31:0]            mem_wdata;
    logic [31:0]            mem_rdata;

    // LSU side: serves core requests and masters the memory port
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    // Environment side: core issuing requests plus the memory model
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit driving a 32-bit word-addressed data memory.
// Byte-addressed byte/half/word accesses; loads are lane-extracted and
// extended, sub-word stores use read-modify-write. One response per request.
module dmem_lsu #(
    parameter int WORD_ADDR_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_lsu_if.slave  bus,
    output logic [2:0] fsm_state
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STORE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic                   lat_we;
    logic [1:0]             lat_size;
    logic                   lat_signed;
    logic [WORD_ADDR_W+1:0] lat_addr;
    logic [31:0]            lat_wdata;
    logic [31:0]            merge_q;
    logic [31:0]            rdata_q;
    logic                   err_q;

    logic                   accept;
    logic                   misaligned;
    logic [4:0]             shamt;
    logic [31:0]            lane;
    logic [31:0]            load_ext;
    logic [31:0]            lane_mask;
    logic [31:0]            merged;

    // Reset gates acceptance directly so nothing is taken while rst_n is low
    assign bus.req_ready = (state == S_IDLE) & rst_n;
    assign accept        = bus.req_valid & bus.req_ready;
    assign fsm_state     = state;

    // Alignment check on the live request, used only at acceptance
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = |bus.req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (misaligned)               state_nxt = S_RESP;
                    else if (!bus.req_we)         state_nxt = S_LOAD;
                    else if (bus.req_size == 2'b10) state_nxt = S_STORE;
                    else                          state_nxt = S_RMW_RD;
                end
            end
            S_LOAD:   state_nxt = S_RESP;
            S_STORE:  state_nxt = S_RESP;
            S_RMW_RD: state_nxt = S_RMW_WR;
            S_RMW_WR: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores.
    // Word accesses are aligned, so the shift is zero for them.
    always_comb begin
        shamt     = {lat_addr[1:0], 3'b000};
        lane      = bus.mem_rdata >> shamt;
        lane_mask = (lat_size == 2'b00) ? (32'h0000_00ff << shamt) : (32'h0000_ffff << shamt);
        merged    = (bus.mem_rdata & ~lane_mask) | ((lat_wdata << shamt) & lane_mask);
        case (lat_size)
            2'b00:   load_ext = {{24{lat_signed & lane[7]}}, lane[7:0]};
            2'b01:   load_ext = {{16{lat_signed & lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Memory port decodes only from state and the latched request
    always_comb begin
        bus.mem_read  = (state == S_LOAD) | (state == S_RMW_RD);
        bus.mem_write = (state == S_STORE) | (state == S_RMW_WR);
        bus.mem_addr  = lat_addr[WORD_ADDR_W+1:2];
        bus.mem_wdata = 32'h0;
        if (state == S_STORE)       bus.mem_wdata = lat_wdata;
        else if (state == S_RMW_WR) bus.mem_wdata = merge_q;
    end

    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // State, request latch, merge register and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lat_we     <= 1'b0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= 32'h0;
            merge_q    <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_we     <= bus.req_we;
                lat_size   <= bus.req_size;
                lat_signed <= bus.req_signed;
                lat_addr   <= bus.req_addr;
                lat_wdata  <= bus.req_wdata;
            end
            // Response fields change only on the edge entering RESP
            if (accept && misaligned) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b1;
            end
            if (state == S_LOAD) begin
                rdata_q <= load_ext;
                err_q   <= 1'b0;
            end
            if (state == S_STORE || state == S_RMW_WR) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
            if (state == S_RMW_RD) merge_q <= merged;
        end
    end

    // lat_we only steers the IDLE decision via the live request; keep it for debug visibility
    logic unused_ok;
    assign unused_ok = lat_we;
endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: table of single requests, a back-to-back
// load burst and a reset-during-RMW sequence, with a word memory model.
module tb_dmem_lsu;
    localparam int W = 8;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] mwdata;
        int          lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] fsm_state;
    logic       mem_clr = 1'b1;

    dmem_lsu_if #(.WORD_ADDR_W(W)) bus();

    dmem_lsu #(.WORD_ADDR_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Word memory model: combinational read, write on posedge, no reset
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 6) ? 32'h600D_F00D : 32'h0;
        end else if (bus.mem_write === 1'b1) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    always_comb bus.mem_rdata = (bus.mem_read === 1'b1) ? mem[bus.mem_addr] : 32'h0;

    // Scoreboard state
    logic [32:0] exp_q[$];
    int          exp_cyc_q[$];
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0;
    logic [7:0]  last_wr_addr;
    logic [31:0] last_wr_data;
    int          last_wr_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: memory activity and response scoreboard
    always @(negedge clk) begin
        logic [32:0] e;
        int          ec;
        if (bus.mem_read === 1'b1) rd_cnt++;
        if (bus.mem_write === 1'b1) begin
            wr_cnt++;
            last_wr_addr = bus.mem_addr;
            last_wr_data = bus.mem_wdata;
            last_wr_cyc  = cyc;
        end
        if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) both_cnt++;
        if (bus.resp_valid === 1'b1) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got err=%0b rdata=%0h expected no response", bus.resp_err, bus.resp_rdata);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("resp_err_rdata", 64'({bus.resp_err, bus.resp_rdata}), 64'(e));
                check("resp_cycle", 64'(cyc), 64'(ec));
            end
        end
    end

    // Driver: present one request at a negedge, wait (bounded) for acceptance
    task automatic send(input vec_t v, input bit expect_resp, output int acc);
        int n;
        bus.req_we     = v.we;
        bus.req_size   = v.size;
        bus.req_signed = v.sgn;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.req_valid  = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (bus.req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=%0b expected 1 within 20 cycles", bus.req_ready);
        end else if (expect_resp) begin
            exp_q.push_back({v.err, v.rdata});
            exp_cyc_q.push_back(cyc + v.lat);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    vec_t        vt[16];
    logic [31:0] tp_exp[4];
    int          acc_t[4];

    initial begin
        int acc, wr0, rd0, r0, n;
        vec_t vr;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_err", 64'(bus.resp_err), 64'd0);
        check("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
        check("rst_mem_read", 64'(bus.mem_read), 64'd0);
        check("rst_mem_write", 64'(bus.mem_write), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_state", 64'(fsm_state), 64'd0);
        mem_clr = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(bus.req_ready), 64'd1);

        //            we    size  sgn   addr     wdata          err   rdata          mwdata         lat
        vt[0]  = '{1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0, 32'h00000000, 32'hDEADBEEF, 2};
        vt[1]  = '{1'b0, 2'd2, 1'b0, 10'h010, 32'h00000000, 1'b0, 32'hDEADBEEF, 32'h00000000, 2};
        vt[2]  = '{1'b1, 2'd0, 1'b0, 10'h011, 32'h000000A5, 1'b0, 32'h00000000, 32'hDEADA5EF, 3};
        vt[3]  = '{1'b0, 2'd0, 1'b1, 10'h011, 32'h00000000, 1'b0, 32'hFFFFFFA5, 32'h00000000, 2};
        vt[4]  = '{1'b0, 2'd0, 1'b0, 10'h011, 32'h00000000, 1'b0, 32'h000000A5, 32'h00000000, 2};
        vt[5]  = '{1'b0, 2'd1, 1'b1, 10'h012, 32'h00000000, 1'b0, 32'hFFFFDEAD, 32'h00000000, 2};
        vt[6]  = '{1'b0, 2'd1, 1'b0, 10'h012, 32'h00000000, 1'b0, 32'h0000DEAD, 32'h00000000, 2};
        vt[7]  = '{1'b0, 2'd2, 1'b0, 10'h013, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 1};
        vt[8]  = '{1'b1, 2'd1, 1'b0, 10'h011, 32'h0000BEEF, 1'b1, 32'h00000000, 32'h00000000, 1};
        vt[9]  = '{1'b0, 2'd3, 1'b0, 10'h010, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 1};
        vt[10] = '{1'b1, 2'd1, 1'b0, 10'h016, 32'h12348001, 1'b0, 32'h00000000, 32'h80010000, 3};
        vt[11] = '{1'b0, 2'd1, 1'b1, 10'h016, 32'h00000000, 1'b0, 32'hFFFF8001, 32'h00000000, 2};
        vt[12] = '{1'b1, 2'd0, 1'b0, 10'h014, 32'h0000FF80, 1'b0, 32'h00000000, 32'h80010080, 3};
        vt[13] = '{1'b0, 2'd0, 1'b1, 10'h014, 32'h00000000, 1'b0, 32'hFFFFFF80, 32'h00000000, 2};
        vt[14] = '{1'b0, 2'd0, 1'b0, 10'h017, 32'h00000000, 1'b0, 32'h00000080, 32'h00000000, 2};
        vt[15] = '{1'b1, 2'd2, 1'b0, 10'h01C, 32'hCAFE0007, 1'b0, 32'h00000000, 32'hCAFE0007, 2};

        // Table-driven single requests with random idle gaps
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            wr0 = wr_cnt;
            rd0 = rd_cnt;
            send(vt[i], 1'b1, acc);
            drain();
            if (vt[i].err) begin
                check("err_no_mem_read", 64'(rd_cnt - rd0), 64'd0);
                check("err_no_mem_write", 64'(wr_cnt - wr0), 64'd0);
            end else if (vt[i].we) begin
                check("st_write_count", 64'(wr_cnt - wr0), 64'd1);
                check("st_read_count", 64'(rd_cnt - rd0), (vt[i].size == 2'd2) ? 64'd0 : 64'd1);
                check("st_wdata", 64'(last_wr_data), 64'(vt[i].mwdata));
                check("st_addr", 64'(last_wr_addr), 64'(vt[i].addr[9:2]));
                check("st_write_cycle", 64'(last_wr_cyc), 64'(acc + vt[i].lat - 1));
            end else begin
                check("ld_read_count", 64'(rd_cnt - rd0), 64'd1);
                check("ld_write_count", 64'(wr_cnt - wr0), 64'd0);
            end
        end

        // Back-to-back word loads with req_valid held high
        tp_exp = '{32'hDEADA5EF, 32'h80010080, 32'h600DF00D, 32'hCAFE0007};
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_signed = 1'b0; bus.req_wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            bus.req_addr = 10'h010 + 10'(4 * k);
            n = 0;
            while (bus.req_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            acc_t[k] = cyc;
            if (bus.req_ready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL burst_accept_timeout: got req_ready=%0b expected 1", bus.req_ready);
            end else begin
                exp_q.push_back({1'b0, tp_exp[k]});
                exp_cyc_q.push_back(cyc + 2);
            end
            @(negedge clk);
            check("burst_ready_busy", 64'(bus.req_ready), 64'd0);
        end
        bus.req_valid = 1'b0;
        drain();
        for (int k = 1; k < 4; k++) check("burst_spacing", 64'(acc_t[k] - acc_t[k-1]), 64'd3);

        // Reset asserted while a byte store is in RMW_RD
        vr  = '{1'b1, 2'd0, 1'b0, 10'h018, 32'h00000011, 1'b0, 32'h0, 32'h0, 3};
        wr0 = wr_cnt;
        r0  = resp_cnt;
        send(vr, 1'b0, acc);
        check("rmw_rd_state", 64'(fsm_state), 64'd3);
        rst_n = 1'b0;
        check("ready_in_rst_busy", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("ready_in_rst_idle", 64'(bus.req_ready), 64'd0);
        check("rst_abort_state", 64'(fsm_state), 64'd0);
        check("rst_abort_read", 64'(bus.mem_read), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 64'(bus.req_ready), 64'd1);
        repeat (4) @(negedge clk);
        check("abort_no_write", 64'(wr_cnt - wr0), 64'd0);
        check("abort_mem_word", 64'(mem[6]), 64'h600DF00D);
        check("abort_no_resp", 64'(resp_cnt - r0), 64'd0);

        // Global invariants
        check("read_write_overlap", 64'(both_cnt), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
